// File: rtl/reg_writeback_pkg.sv
// reg_writeback_pkg: shared defaults for the register-file write-back slice.
// Optional feature macro used by the top: WB_FWD_EN (write-stage forwarding).
package reg_writeback_pkg;

    localparam int XLEN_DEF   = 64;  // register file word width
    localparam int ADDR_W_DEF = 5;   // 32 architectural registers
    localparam int DEPTH_DEF  = 4;   // load FIFO entries
    localparam int X0         = 0;   // hard-wired zero register index

endpackage

// File: rtl/reg_writeback_wb_fifo.sv
// wb_fifo: small synchronous FIFO holding {rd, data} load entries that lost
// arbitration for the write port. Pointers carry one extra wrap bit so
// full/empty are distinguished without a counter.
module wb_fifo #(
    parameter int W     = 69,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign dout  = mem[rptr[AW-1:0]];

    // Pointer update; reset empties the FIFO without touching storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) wptr <= wptr + (AW+1)'(1);
            if (pop && !empty) rptr <= rptr + (AW+1)'(1);
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: drives the register-file write port. Each cycle at most one
// result is registered, ALU first, then the oldest buffered load, then a load
// arriving this cycle. A pending-load scoreboard feeds the decode stall.
// Optional feature: define WB_FWD_EN to forward the write stage to rs1/rs2.
module reg_writeback
    import reg_writeback_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_rd,
    input  logic [XLEN-1:0]   ld_data,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              stall,
    output logic              writereg,
    output logic [ADDR_W-1:0] rd,
    output logic [XLEN-1:0]   writedata,
    output logic              fwd1_hit,
    output logic              fwd2_hit,
    output logic [XLEN-1:0]   fwd1_data,
    output logic [XLEN-1:0]   fwd2_data
);
    localparam int EW   = ADDR_W + XLEN;
    localparam int NREG = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] RZ = ADDR_W'(X0);

    logic              fifo_full, fifo_empty, fifo_push, fifo_pop, ld_acc;
    logic [EW-1:0]     fifo_head;
    logic              sel_valid, sel_ld;
    logic [ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]   sel_data;
    logic [NREG-1:0]   pending;

    // Ready depends only on FIFO occupancy, so a full FIFO never takes a
    // load even if it pops this cycle.
    assign ld_ready = !fifo_full;
    assign ld_acc   = ld_valid && ld_ready;

    wb_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   ({ld_rd, ld_data}),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Source arbitration: ALU > FIFO head > bypass of the incoming load.
    always_comb begin
        sel_valid = 1'b0;
        sel_ld    = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        fifo_pop  = 1'b0;
        fifo_push = 1'b0;
        if (alu_valid) begin
            sel_valid = 1'b1;
            sel_rd    = alu_rd;
            sel_data  = alu_data;
            fifo_push = ld_acc;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel_ld    = 1'b1;
            {sel_rd, sel_data} = fifo_head;
            fifo_pop  = 1'b1;
            fifo_push = ld_acc;
        end else if (ld_acc) begin
            sel_valid = 1'b1;
            sel_ld    = 1'b1;
            sel_rd    = ld_rd;
            sel_data  = ld_data;
        end
    end

    // Output stage; x0 results are consumed but never enable the write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            writereg  <= 1'b0;
            rd        <= '0;
            writedata <= '0;
        end else begin
            writereg <= sel_valid && (sel_rd != RZ);
            if (sel_valid) begin
                rd        <= sel_rd;
                writedata <= sel_data;
            end
        end
    end

    // Scoreboard: the later set overrides a same-cycle clear of one index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            if (sel_valid && sel_ld) pending[sel_rd] <= 1'b0;
            if (iss_valid && (iss_rd != RZ)) pending[iss_rd] <= 1'b1;
        end
    end

`ifdef WB_FWD_EN
    assign fwd1_hit  = writereg && (rd == rs1) && (rs1 != RZ);
    assign fwd2_hit  = writereg && (rd == rs2) && (rs2 != RZ);
    assign fwd1_data = writedata;
    assign fwd2_data = writedata;
`else
    assign fwd1_hit  = 1'b0;
    assign fwd2_hit  = 1'b0;
    assign fwd1_data = '0;
    assign fwd2_data = '0;
`endif

    // A forwarded source is already available, so it does not stall.
    assign stall = (pending[rs1] && !fwd1_hit) || (pending[rs2] && !fwd2_hit);

    // Issuing a load to a register that already has one outstanding is illegal.
    a_no_double_issue: assert property (@(posedge clk) disable iff (!rst_n)
        !(iss_valid && (iss_rd != RZ) && pending[iss_rd]));

endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed scenarios plus randomized traffic against a
// queue-based reference model of the write-back stage.
module tb_reg_writeback;
    localparam int XL = 64;
    localparam int AW = 5;
    localparam int DP = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alu_valid, ld_valid, iss_valid;
    logic [AW-1:0] alu_rd, ld_rd, iss_rd, rs1, rs2;
    logic [XL-1:0] alu_data, ld_data;
    logic          ld_ready, stall, writereg, fwd1_hit, fwd2_hit;
    logic [AW-1:0] rd;
    logic [XL-1:0] writedata, fwd1_data, fwd2_data;

    reg_writeback dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
        .stall(stall), .writereg(writereg), .rd(rd), .writedata(writedata),
        .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
        .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
    );

    always #5 clk = ~clk;

    // Reference model: accepted loads queue up; each cycle the ALU wins,
    // otherwise the oldest load is written.
    typedef struct { logic [AW-1:0] rd; logic [XL-1:0] data; } ent_t;
    ent_t          q[$];
    bit            pend[32];
    logic          exp_we;
    logic [AW-1:0] exp_rd;
    logic [XL-1:0] exp_data;
    int            vectors = 0;
    int            errors  = 0;
`ifdef WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    function automatic logic m_ready();
        return q.size() < DP;
    endfunction

    function automatic logic m_fwd(input logic [AW-1:0] rs);
        return FWD && exp_we && (exp_rd == rs) && (rs != 0);
    endfunction

    function automatic logic m_stall();
        return (pend[rs1] && !m_fwd(rs1)) || (pend[rs2] && !m_fwd(rs2));
    endfunction

    task automatic m_reset();
        q.delete();
        foreach (pend[i]) pend[i] = 1'b0;
        exp_we = 1'b0; exp_rd = '0; exp_data = '0;
    endtask

    task automatic idle();
        alu_valid = 0; ld_valid = 0; iss_valid = 0;
    endtask

    // Advance one clock and update the model with the inputs seen at the edge.
    task automatic tick();
        bit   acc = ld_valid && m_ready();
        bit   sel = 0, isld = 0;
        ent_t e;
        @(posedge clk); #1;
        if (acc) q.push_back('{ld_rd, ld_data});
        if (alu_valid) begin sel = 1; e = '{alu_rd, alu_data}; end
        else if (q.size() > 0) begin sel = 1; isld = 1; e = q.pop_front(); end
        if (isld) pend[e.rd] = 1'b0;
        if (iss_valid && iss_rd != 0) pend[iss_rd] = 1'b1;
        pend[0] = 1'b0;
        exp_we = sel && (e.rd != 0);
        if (sel) begin exp_rd = e.rd; exp_data = e.data; end
    endtask

    task automatic test_reset();
        logic [XL-1:0] d;
        idle(); rs1 = 0; rs2 = 0; alu_rd = 0; ld_rd = 0; iss_rd = 0; alu_data = 0; ld_data = 0;
        rst_n = 0; m_reset();
        repeat (2) @(posedge clk); #1;
        vectors++; if (writereg !== 1'b0) begin errors++; $display("FAIL reset_we got=%b exp=0", writereg); end
        vectors++; if (rd !== '0 || writedata !== '0) begin errors++; $display("FAIL reset_rd_data got=%0d/%h exp=0/0", rd, writedata); end
        vectors++; if (ld_ready !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL reset_ready_stall got=%b/%b exp=1/0", ld_ready, stall); end
        vectors++; if (fwd1_hit !== 0 || fwd2_hit !== 0 || fwd1_data !== '0 || fwd2_data !== '0) begin errors++; $display("FAIL reset_fwd got=%b%b exp=00", fwd1_hit, fwd2_hit); end
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        // Mid-traffic: three loads buffered behind ALU writes, x9 pending.
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1; alu_rd = AW'(20 + i); alu_data = {$urandom, $urandom};
            ld_valid = 1; ld_rd = AW'(10 + i); ld_data = {$urandom, $urandom};
            iss_valid = (i == 0); iss_rd = 9;
            tick();
        end
        idle(); rs1 = 9;
        #1;
        vectors++; if (stall !== 1'b1) begin errors++; $display("FAIL pre_reset_stall got=%b exp=1", stall); end
        rst_n = 0; m_reset();
        #1;
        vectors++; if (writereg !== 0 || ld_ready !== 1 || stall !== 0) begin errors++; $display("FAIL midreset got we/rdy/stall=%b%b%b exp=010", writereg, ld_ready, stall); end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            vectors++; if (writereg !== 1'b0) begin errors++; $display("FAIL midreset_hold_we got=%b exp=0", writereg); end
        end
        @(negedge clk); rst_n = 1; d = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (writereg !== 1'b0 || ld_ready !== 1'b1) begin errors++; $display("FAIL post_reset_drain got we/rdy=%b%b exp=01", writereg, ld_ready); end
        end
        rs1 = 0;
    endtask

    task automatic test_alu();
        idle(); alu_valid = 1; alu_rd = 5; alu_data = 64'h1234;
        tick();
        vectors++; if (writereg !== 1 || rd !== 5 || writedata !== 64'h1234) begin errors++; $display("FAIL alu_only got=%b/%0d/%h exp=1/5/1234", writereg, rd, writedata); end
        idle();
        tick();
        vectors++; if (writereg !== 0 || rd !== 5 || writedata !== 64'h1234) begin errors++; $display("FAIL idle_hold got=%b/%0d/%h exp=0/5/1234", writereg, rd, writedata); end
    endtask

    task automatic test_collision();
        idle(); alu_valid = 1; alu_rd = 3; alu_data = 64'hAAAA;
        ld_valid = 1; ld_rd = 7; ld_data = 64'h7777;
        tick();
        vectors++; if (writereg !== 1 || rd !== 3 || writedata !== 64'hAAAA) begin errors++; $display("FAIL collide_alu got=%b/%0d/%h exp=1/3/aaaa", writereg, rd, writedata); end
        idle();
        tick();
        vectors++; if (writereg !== 1 || rd !== 7 || writedata !== 64'h7777) begin errors++; $display("FAIL collide_ld got=%b/%0d/%h exp=1/7/7777", writereg, rd, writedata); end
        tick();
        vectors++; if (writereg !== 0) begin errors++; $display("FAIL collide_after got=%b exp=0", writereg); end
    endtask

    task automatic test_backpressure();
        logic [XL-1:0] ld_d [5];
        for (int i = 0; i < 5; i++) begin
            ld_d[i] = {$urandom, $urandom};
            alu_valid = 1; alu_rd = AW'(20 + i); alu_data = {$urandom, $urandom};
            ld_valid = 1; ld_rd = AW'(10 + i); ld_data = ld_d[i]; iss_valid = 0;
            #1;
            vectors++; if (ld_ready !== (i < 4) || ld_ready !== m_ready()) begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=%b", i, ld_ready, i < 4); end
            tick();
            vectors++; if (writereg !== 1 || rd !== AW'(20 + i)) begin errors++; $display("FAIL bp_alu[%0d] got=%b/%0d exp=1/%0d", i, writereg, rd, 20 + i); end
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++; if (writereg !== 1 || rd !== AW'(10 + i) || writedata !== ld_d[i]) begin errors++; $display("FAIL bp_drain[%0d] got=%b/%0d/%h exp=1/%0d/%h", i, writereg, rd, writedata, 10 + i, ld_d[i]); end
        end
        tick();
        vectors++; if (writereg !== 0 || ld_ready !== 1) begin errors++; $display("FAIL bp_empty got we/rdy=%b%b exp=01", writereg, ld_ready); end
    endtask

    task automatic test_scoreboard();
        idle(); iss_valid = 1; iss_rd = 9; rs1 = 9; rs2 = 0;
        #1;
        vectors++; if (stall !== 0) begin errors++; $display("FAIL sb_before got=%b exp=0", stall); end
        tick(); idle();
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++; if (stall !== 1) begin errors++; $display("FAIL sb_wait[%0d] got=%b exp=1", i, stall); end
            tick();
        end
        ld_valid = 1; ld_rd = 9; ld_data = 64'h99;
        #1;
        vectors++; if (stall !== 1) begin errors++; $display("FAIL sb_ld_offer got=%b exp=1", stall); end
        tick(); idle();
        vectors++; if (writereg !== 1 || rd !== 9 || stall !== 0) begin errors++; $display("FAIL sb_clear got=%b/%0d/%b exp=1/9/0", writereg, rd, stall); end
        rs1 = 0; iss_valid = 1; iss_rd = 0;
        tick(); idle();
        vectors++; if (stall !== 0) begin errors++; $display("FAIL sb_x0 got=%b exp=0", stall); end
    endtask

    task automatic test_x0_fwd();
        idle(); iss_valid = 1; iss_rd = 12; rs1 = 12; rs2 = 0;
        tick(); idle();
        ld_valid = 1; ld_rd = 0; ld_data = 64'hDEAD;
        tick(); idle();
        vectors++; if (writereg !== 0 || stall !== 1) begin errors++; $display("FAIL x0_load got we/stall=%b%b exp=01", writereg, stall); end
        ld_valid = 1; ld_rd = 12; ld_data = 64'h12;
        tick(); idle();
        vectors++; if (writereg !== 1 || rd !== 12 || stall !== 0) begin errors++; $display("FAIL x0_then_x12 got=%b/%0d/%b exp=1/12/0", writereg, rd, stall); end
        // Write x4 while issuing a load to x4: only forwarding hides the hazard.
        rs1 = 0; rs2 = 4;
        alu_valid = 1; alu_rd = 4; alu_data = {$urandom, $urandom}; iss_valid = 1; iss_rd = 4;
        tick(); idle();
        vectors++; if (fwd2_hit !== FWD || fwd2_data !== (FWD ? exp_data : '0) || fwd1_hit !== 0) begin errors++; $display("FAIL fwd2 got=%b/%h exp=%b", fwd2_hit, fwd2_data, FWD); end
        vectors++; if (stall !== !FWD || stall !== m_stall()) begin errors++; $display("FAIL fwd_stall_mask got=%b exp=%b", stall, !FWD); end
        ld_valid = 1; ld_rd = 4; ld_data = 64'h4;
        tick(); idle(); rs2 = 0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            alu_valid = ($urandom_range(0, 1) == 1);
            alu_rd = AW'($urandom); alu_data = {$urandom, $urandom};
            ld_valid = ($urandom_range(0, 9) < 6);
            ld_rd = AW'($urandom); ld_data = {$urandom, $urandom};
            iss_rd = AW'($urandom);
            iss_valid = ($urandom_range(0, 9) < 3) && !pend[iss_rd];
            rs1 = AW'($urandom); rs2 = AW'($urandom);
            #1;
            vectors++; if (ld_ready !== m_ready()) begin errors++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", n, ld_ready, m_ready()); end
            vectors++; if (stall !== m_stall()) begin errors++; $display("FAIL rnd_stall[%0d] got=%b exp=%b", n, stall, m_stall()); end
            tick();
            vectors++; if (writereg !== exp_we) begin errors++; $display("FAIL rnd_we[%0d] got=%b exp=%b", n, writereg, exp_we); end
            if (exp_we) begin
                vectors++; if (rd !== exp_rd || writedata !== exp_data) begin errors++; $display("FAIL rnd_wr[%0d] got=%0d/%h exp=%0d/%h", n, rd, writedata, exp_rd, exp_data); end
            end
            vectors++; if (fwd1_hit !== m_fwd(rs1) || fwd2_hit !== m_fwd(rs2)) begin errors++; $display("FAIL rnd_fwd[%0d] got=%b%b exp=%b%b", n, fwd1_hit, fwd2_hit, m_fwd(rs1), m_fwd(rs2)); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_collision();
        test_backpressure();
        test_scoreboard();
        test_x0_fwd();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
